ps2_tx: RTL

- Host-to-device PS/2 transmitter. It sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) using the PS/2 request-to-send protocol.
- It is the counterpart of the keyboard receive path. Clock and data lines are shared, open-drain.
- Receive logic must ignore line activity while busy=1.

---
 rtl/ps2_tx.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device command transmitter
// Drives one byte to the device using the request-to-send sequence over open-drain lines.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       kbclk_in,
  input  logic       kbdata_in,
  output logic       kbclk_oe,
  output logic       kbdata_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);
  localparam int TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW = $clog2(TMR_MAX + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic            clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic            dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic            clk_filt_q, clk_filt_d;
  logic [FW-1:0]   flt_cnt_q, flt_cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [8:0]      shreg_q, shreg_d;
  logic            kbclk_oe_q, kbclk_oe_d;
  logic            kbdata_oe_q, kbdata_oe_d;
  logic            done_q, done_d;
  logic            ack_err_q, ack_err_d;
  logic            timeout_err_q, timeout_err_d;
  logic            fall;

  // Glitch filter: the level only follows the synchronized line after FILTER_LEN agreeing samples.
  always_comb begin
    clk_s1_d   = kbclk_in;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = kbdata_in;
    dat_s2_d   = dat_s1_q;
    clk_filt_d = clk_filt_q;
    flt_cnt_d  = '0;
    if (clk_s2_q != clk_filt_q) begin
      if (flt_cnt_q == FLT_LAST) clk_filt_d = clk_s2_q;
      else                       flt_cnt_d  = flt_cnt_q + 1'b1;
    end
  end

  assign fall = clk_filt_q & ~clk_filt_d;

  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    bit_idx_d     = bit_idx_q;
    shreg_d       = shreg_q;
    kbdata_oe_d   = kbdata_oe_q;
    done_d        = 1'b0;
    ack_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        kbdata_oe_d = 1'b0;
        tmr_d       = '0;
        bit_idx_d   = '0;
        if (tx_valid) begin
          shreg_d = {~^tx_data, tx_data};
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (tmr_q == INH_LAST) begin
          tmr_d       = '0;
          kbdata_oe_d = 1'b1;
          state_d     = S_RTS;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_RTS: begin
        tmr_d   = '0;
        state_d = S_SEND;
      end
      S_SEND, S_ACK, S_WAIT_IDLE: begin
        // Timeout wins over a fall seen in the same cycle.
        if (tmr_q == TO_LAST) begin
          tmr_d         = '0;
          kbdata_oe_d   = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else if (fall) begin
          tmr_d = '0;
          if (state_q == S_SEND) begin
            if (bit_idx_q == 4'd9) begin
              kbdata_oe_d = 1'b0;
              bit_idx_d   = '0;
              state_d     = S_ACK;
            end else begin
              kbdata_oe_d = ~shreg_q[0];
              shreg_d     = {1'b0, shreg_q[8:1]};
              bit_idx_d   = bit_idx_q + 4'd1;
            end
          end else if (state_q == S_ACK) begin
            if (dat_s2_q) begin
              ack_err_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              state_d = S_WAIT_IDLE;
            end
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
          if (state_q == S_WAIT_IDLE && clk_filt_q && dat_s2_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    kbclk_oe_d = (state_d == S_INHIBIT) || (state_d == S_RTS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      clk_s1_q      <= 1'b1;
      clk_s2_q      <= 1'b1;
      dat_s1_q      <= 1'b1;
      dat_s2_q      <= 1'b1;
      clk_filt_q    <= 1'b1;
      flt_cnt_q     <= '0;
      tmr_q         <= '0;
      bit_idx_q     <= '0;
      shreg_q       <= '0;
      kbclk_oe_q    <= 1'b0;
      kbdata_oe_q   <= 1'b0;
      done_q        <= 1'b0;
      ack_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_s1_q      <= clk_s1_d;
      clk_s2_q      <= clk_s2_d;
      dat_s1_q      <= dat_s1_d;
      dat_s2_q      <= dat_s2_d;
      clk_filt_q    <= clk_filt_d;
      flt_cnt_q     <= flt_cnt_d;
      tmr_q         <= tmr_d;
      bit_idx_q     <= bit_idx_d;
      shreg_q       <= shreg_d;
      kbclk_oe_q    <= kbclk_oe_d;
      kbdata_oe_q   <= kbdata_oe_d;
      done_q        <= done_d;
      ack_err_q     <= ack_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = ~tx_ready;
  assign kbclk_oe    = kbclk_oe_q;
  assign kbdata_oe   = kbdata_oe_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout_err = timeout_err_q;
endmodule
